// File: rtl/cla_16bit_addsub_pipe.sv
// Two-stage pipelined 16-bit adder/subtractor: stage 1 adds the low byte, stage 2
// adds the high byte from the registered carry. Valid/ready handshake on both sides.
module cla_16bit_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int HALF  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // 8-bit CLA built from two 4-bit groups; returns {c8, c7, sum[7:0]}.
  // c7 is kept so the high slice can form signed overflow as c16 ^ c15.
  function automatic logic [9:0] cla8(input logic [7:0] a, input logic [7:0] b,
                                      input logic c0);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       gg0;
    logic       gp0;
    logic       gg1;
    logic       gp1;
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    gg0  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp0  = &p[3:0];
    c[4] = gg0 | (gp0 & c[0]);
    c[5] = g[4] | (p[4] & c[4]);
    c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
    c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]) | (p[6] & p[5] & p[4] & c[4]);
    gg1  = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4]);
    gp1  = &p[7:4];
    c[8] = gg1 | (gp1 & gg0) | (gp1 & gp0 & c[0]);
    return {c[8], c[7], p ^ c[7:0]};
  endfunction

  logic            s1_valid_q, s1_valid_d;
  logic [HALF-1:0] s1_lo_q, s1_lo_d;
  logic            s1_c8_q, s1_c8_d;
  logic [HALF-1:0] s1_ahi_q, s1_ahi_d;
  logic [HALF-1:0] s1_bhi_q, s1_bhi_d;
  logic            s1_sub_q, s1_sub_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             s2_ready;
  logic             s1_fire;
  logic             s2_fire;
  logic [WIDTH-1:0] b_eff;
  logic             c0_eff;
  logic [9:0]       lo_res;
  logic [9:0]       hi_res;

  assign s2_ready  = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_ready;
  assign s1_fire   = in_valid && in_ready;
  assign s2_fire   = s1_valid_q && s2_ready;

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Operand conditioning and both CLA slices.
  always_comb begin
    b_eff  = sub ? ~in2 : in2;
    c0_eff = sub ? 1'b1 : cin;
    lo_res = cla8(in1[HALF-1:0], b_eff[HALF-1:0], c0_eff);
    hi_res = cla8(s1_ahi_q, s1_bhi_q, s1_c8_q);
  end

  // Stage 1 next state: load on accept, drop valid when drained without refill.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_c8_d    = s1_c8_q;
    s1_ahi_d   = s1_ahi_q;
    s1_bhi_d   = s1_bhi_q;
    s1_sub_d   = s1_sub_q;
    if (s1_fire) begin
      s1_valid_d = 1'b1;
      s1_lo_d    = lo_res[7:0];
      s1_c8_d    = lo_res[9];
      s1_ahi_d   = in1[WIDTH-1:HALF];
      s1_bhi_d   = b_eff[WIDTH-1:HALF];
      s1_sub_d   = sub;
    end else if (s2_fire) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: form the full result and flags when stage 1 advances.
  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    if (s2_fire) begin
      s2_valid_d = 1'b1;
      result_d   = {hi_res[7:0], s1_lo_q};
      cout_d     = s1_sub_q ? ~hi_res[9] : hi_res[9];
      ovf_d      = hi_res[9] ^ hi_res[8];
      zero_d     = ({hi_res[7:0], s1_lo_q} == 16'd0);
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= 8'd0;
      s1_c8_q    <= 1'b0;
      s1_ahi_q   <= 8'd0;
      s1_bhi_q   <= 8'd0;
      s1_sub_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= 16'd0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_c8_q    <= s1_c8_d;
      s1_ahi_q   <= s1_ahi_d;
      s1_bhi_q   <= s1_bhi_d;
      s1_sub_q   <= s1_sub_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

endmodule

// File: tb/tb_cla_16bit_addsub_pipe.sv
// Self-checking bench for cla_16bit_addsub_pipe: arithmetic reference model,
// in-order expectation queue and one per-cycle compare process.
module tb_cla_16bit_addsub_pipe;

  typedef struct {
    logic [18:0] exp;
    int          acc;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_acc = 0;
  item_t       q[$];
  logic        held_f = 1'b0;
  logic [18:0] held_v = 19'd0;

  cla_16bit_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic; returns {result, cout/borrow, ovf, zero}.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic s);
    int ua, ub, sa, sb, ur, sr;
    logic [15:0] r;
    logic co, ov;
    ua = int'({16'd0, a});
    ub = int'({16'd0, b});
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua < ub);
    end else begin
      ur = ua + ub + int'({31'd0, c});
      sr = sa + sb + int'({31'd0, c});
      co = (ur > 65535);
    end
    r  = ur[15:0];
    ov = (sr > 32767) || (sr < -32768);
    return {r, co, ov, (r == 16'd0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: handshake, 2-cycle latency, ordering, data and hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_f <= 1'b0;
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || out_ready});
      chk("out_valid", {31'd0, out_valid},
          {31'd0, (q.size() > 0) && (cyc >= q[0].acc + 2)});
      if (held_f) chk("hold", {12'd0, out_valid, result, cout, ovf, zero}, {12'd0, 1'b1, held_v});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("result", {16'd0, result}, {16'd0, q[0].exp[18:3]});
          chk("cout", {31'd0, cout}, {31'd0, q[0].exp[2]});
          chk("ovf", {31'd0, ovf}, {31'd0, q[0].exp[1]});
          chk("zero", {31'd0, zero}, {31'd0, q[0].exp[0]});
          q.delete(0);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{model(in1, in2, cin, sub), cyc});
        n_acc <= n_acc + 1;
      end
      held_f <= out_valid && !out_ready;
      held_v <= {result, cout, ovf, zero};
    end
  end

  // Present one operand pair (called at posedge+1) and hold it until accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    int k;
    k = 0;
    in1 = a; in2 = b; cin = c; sub = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single op into an empty pipe with literal expectations and exact latency.
  task automatic run_lit(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s, input logic [15:0] er,
                         input logic eco, input logic eov, input logic ez);
    out_ready = 1'b1;
    send(a, b, c, s);
    @(negedge clk);
    chk({name, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({name, "_lat2"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_res"}, {16'd0, result}, {16'd0, er});
    chk({name, "_flags"}, {29'd0, cout, ovf, zero}, {29'd0, eco, eov, ez});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in1 = 16'd0; in2 = 16'd0; cin = 1'b0; sub = 1'b0;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outputs", {13'd0, result, cout, ovf, zero}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pin the reference model to hand-computed values.
    chk("m_add", {13'd0, model(16'd30037, 16'd30049, 1'b0, 1'b0)}, {13'd0, 16'd60086, 3'b010});
    chk("m_s1", {13'd0, model(16'd1024, 16'd2048, 1'b0, 1'b0)}, {13'd0, 16'd3072, 3'b000});
    chk("m_s2", {13'd0, model(16'd32768, 16'd65535, 1'b0, 1'b0)}, {13'd0, 16'd32767, 3'b110});
    chk("m_s3", {13'd0, model(16'd65535, 16'd65535, 1'b0, 1'b0)}, {13'd0, 16'd65534, 3'b100});
    chk("m_s4", {13'd0, model(16'd462, 16'd391, 1'b1, 1'b0)}, {13'd0, 16'd854, 3'b000});
    chk("m_sub1", {13'd0, model(16'd391, 16'd462, 1'b0, 1'b1)}, {13'd0, 16'd65465, 3'b100});
    chk("m_sub2", {13'd0, model(16'd32768, 16'd1, 1'b0, 1'b1)}, {13'd0, 16'd32767, 3'b010});

    run_lit("add", 16'd30037, 16'd30049, 1'b0, 1'b0, 16'd60086, 1'b0, 1'b1, 1'b0);

    out_ready = 1'b1;
    send(16'd1024, 16'd2048, 1'b0, 1'b0);
    send(16'd32768, 16'd65535, 1'b0, 1'b0);
    send(16'd65535, 16'd65535, 1'b0, 1'b0);
    send(16'd462, 16'd391, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    run_lit("sub_a", 16'd462, 16'd391, 1'b1, 1'b1, 16'd71, 1'b0, 1'b0, 1'b0);
    run_lit("sub_b", 16'd391, 16'd462, 1'b0, 1'b1, 16'd65465, 1'b1, 1'b0, 1'b0);
    run_lit("sub_z", 16'd500, 16'd500, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1);
    run_lit("sub_o", 16'd32768, 16'd1, 1'b0, 1'b1, 16'd32767, 1'b0, 1'b1, 1'b0);

    // Backpressure: two fill the pipe, the third waits.
    out_ready = 1'b0;
    send(16'd100, 16'd200, 1'b0, 1'b0);
    send(16'd5000, 16'd7, 1'b0, 1'b1);
    in1 = 16'd4660; in2 = 16'd22136; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'd4660, 16'd22136, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", q.size(), 32'd0);

    // Async reset with both stages full.
    out_ready = 1'b0;
    send(16'd1, 16'd2, 1'b0, 1'b0);
    send(16'd3, 16'd4, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_outputs", {13'd0, result, cout, ovf, zero}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_lit("post_rst", 16'd462, 16'd391, 1'b1, 1'b1, 16'd71, 1'b0, 1'b0, 1'b0);

    // Random stream with random backpressure.
    begin
      int start_acc;
      int k;
      start_acc = n_acc;
      k = 0;
      while ((n_acc - start_acc) < 1000 && k < 20000) begin
        @(posedge clk); #1;
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 3) != 0);
        in1 = rnd16();
        in2 = rnd16();
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        k++;
      end
      if (k >= 20000) chk("rand_timeout", n_acc - start_acc, 32'd1000);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rand_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cla_16bit_addsub_pipe.md
Name: cla_16bit_addsub_pipe

Overview:
Two-stage pipelined 16-bit adder/subtractor built from 8-bit carry-lookahead halves. It accepts operand pairs over a valid/ready handshake and returns sum or difference with carry/borrow, signed-overflow and zero flags. It is the sequential counterpart to the combinational 16-bit CLA: it consumes operands in a stream and delivers results to a downstream consumer with backpressure. Stage 1 computes the low byte; stage 2 computes the high byte from the registered carry.

Parameters:
WIDTH, 16, operand/result width; fixed at 16, split into two equal halves.
HALF, 8, width of each pipeline stage's CLA slice (WIDTH/2).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept operands this cycle.
in1  input  16  operand A.
in2  input  16  operand B.
cin  input  1  carry-in (add) / ignored (sub).
sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result this cycle.
result  output  16  sum/difference.
cout  output  1  add: carry-out; sub: borrow (1 when A<B unsigned).
ovf  output  1  signed two's-complement overflow.
zero  output  1  result == 0.

Behaviour:
- Reset (rst_n=0, async): s1_valid=0, s2_valid=0, out_valid=0, result=0, cout=0, ovf=0, zero=0. Reset mid-operation discards all in-flight data; in_ready=1 after reset.
- Operand B effective = sub ? ~in2 : in2; effective carry-in = sub ? 1 : cin.
- Stage 1 (on in_valid && in_ready): registers low sum = A[7:0]+Beff[7:0]+c0 (8-bit CLA with group P/G), c8, A[15:8], Beff[15:8], sub; s1_valid<=1.
- Stage 2 (on s1_valid && s2_ready): high sum = A[15:8]+Beff[15:8]+c8; registers result={hi,lo}, c16, ovf = c16 XOR c15, zero flag; cout = sub ? ~c16 : c16; s2_valid<=1.
- out_valid = s2_valid; outputs are registered and stable while out_valid && !out_ready.
- Ready chain: s2_ready = !s2_valid || out_ready; in_ready = !s1_valid || s2_ready. in_ready is combinational from out_ready (no skid buffer).
- Stage that is vacated and not refilled clears its valid; data registers hold their value.
- Latency: 2 cycles from accepted input to out_valid with no stall; throughput 1 result/cycle when out_ready held high.
- Full: both stages valid and out_ready=0 -> in_ready=0, no state changes; inputs ignored.
- Simultaneous output accept and input accept in a full pipe: both stages advance in the same cycle, no bubble, no loss, no duplication.
- Ordering strictly FIFO; every accepted input produces exactly one output.
- Wrap-around: arithmetic is modulo 2^16; overflow reported only via cout/ovf.

Test Plan:
- Reset then add 30037+30049, cin=0, out_ready=1 -> out_valid 2 cycles after accept, result=60086, cout=0, ovf=1 (signed), zero=0.
- Back-to-back stream: 1024+2048, 32768+65535, 65535+65535, 462+391 cin=1 on consecutive cycles -> results 3072/0/0/0, 32767/1/1/0, 65534/1/0/0, 854/0/0/0 (result/cout/ovf/zero) on consecutive cycles, in order.
- Subtract: 462-391 -> 71, cout(borrow)=0; 391-462 -> 65465, borrow=1; 500-500 -> 0, zero=1, borrow=0; -32768-1 (32768-1) -> 32767, ovf=1.
- Backpressure: hold out_ready=0 while sending 3 operand pairs -> 2 accepted, in_ready=0 after second, output held stable; release out_ready -> all 3 delivered in order, none lost or duplicated.
- Async reset asserted mid-stream with both stages full -> out_valid and all outputs 0 immediately (before the next clock edge); after release, first new operand pair returns correct result with 2-cycle latency.
- Random 1000 operand pairs with random add/sub, cin and out_ready -> every output matches the golden model (A±B modulo 2^16 with flags), in order.
